// File: rtl/multi_core_best_select.sv
// multi_core_best_select
//   Collects hash results from NUM_CORES cores through a round-robin arbiter
//   and tracks the best (lowest bits-off) result seen since the last reset or
//   reset_best_i. Two-stage pipeline: stage 1 registers the accepted result as
//   a candidate, stage 2 compares it against the running best.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   result_valid_i        per-core result valid
//   result_ready_o        per-core accept, one-hot or zero
//   result_nonce_i        packed nonces, core k at [k*NONCE_W +: NONCE_W]
//   result_bits_off_i     packed scores, core k at [k*BITS_W +: BITS_W]
//   reset_best_i          clears running best and result count
//   best_nonce_o          nonce of the best result
//   best_bits_off_o       best (lowest) score, all-ones when empty
//   best_core_o           core that produced the best result
//   best_update_o         one-cycle pulse when the best registers change
//   result_count_o        accepted results, saturating
//   threshold_i, hit_o    only with BEST_THRESHOLD_HIT_EN defined: hit_o is a
//                         sticky flag set once best_bits_off_o <= threshold_i
module multi_core_best_select #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 256,
  parameter int BITS_W    = 10,
  localparam int IDX_W    = $clog2(NUM_CORES)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CORES-1:0]           result_valid_i,
  output logic [NUM_CORES-1:0]           result_ready_o,
  input  logic [NUM_CORES*NONCE_W-1:0]   result_nonce_i,
  input  logic [NUM_CORES*BITS_W-1:0]    result_bits_off_i,
  input  logic                           reset_best_i,
`ifdef BEST_THRESHOLD_HIT_EN
  input  logic [BITS_W-1:0]              threshold_i,
  output logic                           hit_o,
`endif
  output logic [NONCE_W-1:0]             best_nonce_o,
  output logic [BITS_W-1:0]              best_bits_off_o,
  output logic [IDX_W-1:0]               best_core_o,
  output logic                           best_update_o,
  output logic [31:0]                    result_count_o
);

  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  logic               accept;
  int                 probe;

  logic               cand_valid;
  logic [NONCE_W-1:0] cand_nonce;
  logic [BITS_W-1:0]  cand_bits;
  logic [IDX_W-1:0]   cand_core;

  // Round-robin search starting just above the last granted core.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      probe = (int'(last_grant) + 1 + i) % NUM_CORES;
      if (!grant_found && result_valid_i[probe]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(probe);
      end
    end
  end

  // No handshakes while either reset is active.
  always_comb begin
    result_ready_o = '0;
    if (grant_found && !rst_i && !reset_best_i) begin
      result_ready_o[grant_idx] = 1'b1;
    end
  end

  assign accept = |result_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant      <= IDX_W'(NUM_CORES - 1);
      cand_valid      <= 1'b0;
      cand_nonce      <= '0;
      cand_bits       <= '0;
      cand_core       <= '0;
      best_nonce_o    <= '0;
      best_bits_off_o <= '1;
      best_core_o     <= '0;
      best_update_o   <= 1'b0;
      result_count_o  <= '0;
    end else begin
      best_update_o <= 1'b0;
      cand_valid    <= accept;

      if (accept) begin
        last_grant <= grant_idx;
        cand_nonce <= result_nonce_i[int'(grant_idx)*NONCE_W +: NONCE_W];
        cand_bits  <= result_bits_off_i[int'(grant_idx)*BITS_W +: BITS_W];
        cand_core  <= grant_idx;
        if (result_count_o != 32'hFFFF_FFFF) begin
          result_count_o <= result_count_o + 32'd1;
        end
      end

      // reset_best_i overrides any stage-2 improvement and drops the candidate.
      if (reset_best_i) begin
        cand_valid      <= 1'b0;
        best_nonce_o    <= '0;
        best_bits_off_o <= '1;
        best_core_o     <= '0;
        result_count_o  <= '0;
      end else if (cand_valid && (cand_bits < best_bits_off_o)) begin
        best_nonce_o    <= cand_nonce;
        best_bits_off_o <= cand_bits;
        best_core_o     <= cand_core;
        best_update_o   <= 1'b1;
      end
    end
  end

`ifdef BEST_THRESHOLD_HIT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || reset_best_i) begin
      hit_o <= 1'b0;
    end else if (best_bits_off_o <= threshold_i) begin
      hit_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_core_best_select.sv
module tb_multi_core_best_select;

  localparam int NC = 4;
  localparam int NW = 256;
  localparam int BW = 10;

  typedef struct packed {
    logic [NW-1:0] nonce;
    logic [BW-1:0] bits;
    logic [1:0]    core;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NC-1:0]     result_valid_i;
  logic [NC-1:0]     result_ready_o;
  logic [NC*NW-1:0]  result_nonce_i;
  logic [NC*BW-1:0]  result_bits_off_i;
  logic              reset_best_i;
  logic [NW-1:0]     best_nonce_o;
  logic [BW-1:0]     best_bits_off_o;
  logic [1:0]        best_core_o;
  logic              best_update_o;
  logic [31:0]       result_count_o;
  logic [BW-1:0]     threshold_i = 10'h040;
`ifdef BEST_THRESHOLD_HIT_EN
  logic              hit_o;
`endif

  multi_core_best_select #(.NUM_CORES(NC), .NONCE_W(NW), .BITS_W(BW)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .result_valid_i    (result_valid_i),
    .result_ready_o    (result_ready_o),
    .result_nonce_i    (result_nonce_i),
    .result_bits_off_i (result_bits_off_i),
    .reset_best_i      (reset_best_i),
`ifdef BEST_THRESHOLD_HIT_EN
    .threshold_i       (threshold_i),
    .hit_o             (hit_o),
`endif
    .best_nonce_o      (best_nonce_o),
    .best_bits_off_o   (best_bits_off_o),
    .best_core_o       (best_core_o),
    .best_update_o     (best_update_o),
    .result_count_o    (result_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [NW-1:0] core_nonce [NC];
  logic [BW-1:0] core_bits  [NC];
  logic [NC-1:0] pend;

  // Transaction-level reference: arbiter pointer, running best, count.
  int            m_last;
  logic [BW-1:0] m_bits;
  logic [NW-1:0] m_nonce;
  logic [1:0]    m_core;
  logic [31:0]   m_count;
  logic          last_pushed;

  // Every best_update_o pulse must match the next expected improvement.
  always @(posedge clk_i) begin
    #2;
    if (best_update_o === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL update_unexpected got bits=%h core=%0d required no pulse",
                 best_bits_off_o, best_core_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (best_bits_off_o !== mon_e.bits || best_nonce_o !== mon_e.nonce ||
            best_core_o !== mon_e.core)
          $display("FAIL update_value got bits=%h core=%0d nonce=%h required bits=%h core=%0d nonce=%h",
                   best_bits_off_o, best_core_o, best_nonce_o[31:0],
                   mon_e.bits, mon_e.core, mon_e.nonce[31:0]);
        else n_pass++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [NC-1:0] v, input int last);
    for (int i = 0; i < NC; i++) begin
      if (v[(last + 1 + i) % NC]) return (last + 1 + i) % NC;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_bits      = '1;
    m_nonce     = '0;
    m_core      = '0;
    m_count     = '0;
    last_pushed = 1'b0;
  endtask

  // One cycle: drive inputs after a falling edge, check ready, advance model.
  task automatic step(input logic [NC-1:0] v, input logic rb);
    int            g;
    logic [NC-1:0] exp_rdy;
    exp_t          e;
    result_valid_i = v;
    reset_best_i   = rb;
    for (int k = 0; k < NC; k++) begin
      result_nonce_i[k*NW +: NW]    = core_nonce[k];
      result_bits_off_i[k*BW +: BW] = core_bits[k];
    end
    #1;
    g       = rb ? -1 : rr_pick(v, m_last);
    exp_rdy = (g >= 0) ? NC'(1 << g) : '0;
    n_checks++;
    if (result_ready_o !== exp_rdy)
      $display("FAIL ready got %b required %b", result_ready_o, exp_rdy);
    else n_pass++;
    if (rb) begin
      if (last_pushed) void'(exp_q.pop_back());
      model_clear();
    end else if (g >= 0) begin
      m_last = g;
      if (m_count != 32'hFFFF_FFFF) m_count++;
      pend[g] = 1'b0;
      if (core_bits[g] < m_bits) begin
        m_bits  = core_bits[g];
        m_nonce = core_nonce[g];
        m_core  = 2'(g);
        e.nonce = m_nonce; e.bits = m_bits; e.core = m_core;
        exp_q.push_back(e);
        last_pushed = 1'b1;
      end else last_pushed = 1'b0;
    end else last_pushed = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic drain();
    repeat (3) step('0, 1'b0);
  endtask

  task automatic check_best(input string tag);
    n_checks++;
    if (best_bits_off_o !== m_bits || best_nonce_o !== m_nonce || best_core_o !== m_core)
      $display("FAIL %s_best got bits=%h core=%0d required bits=%h core=%0d",
               tag, best_bits_off_o, best_core_o, m_bits, m_core);
    else n_pass++;
    n_checks++;
    if (result_count_o !== m_count)
      $display("FAIL %s_count got %0d required %0d", tag, result_count_o, m_count);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_missing_update got %0d pending required 0", tag, exp_q.size());
    else n_pass++;
`ifdef BEST_THRESHOLD_HIT_EN
    n_checks++;
    if (hit_o !== (m_bits <= threshold_i))
      $display("FAIL %s_hit got %b required %b", tag, hit_o, (m_bits <= threshold_i));
    else n_pass++;
`endif
  endtask

  task automatic do_reset();
    rst_i          = 1'b1;
    result_valid_i = '0;
    reset_best_i   = 1'b0;
    exp_q.delete();
    model_clear();
    m_last = NC - 1;
    pend   = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i          = 1'b1;
    reset_best_i   = 1'b0;
    result_valid_i = '1;
    for (int k = 0; k < NC; k++) begin core_nonce[k] = '0; core_bits[k] = '0; end
    result_nonce_i    = '0;
    result_bits_off_i = '0;
    model_clear();
    m_last = NC - 1;
    pend   = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (result_ready_o !== '0) $display("FAIL reset_ready got %b required 0000", result_ready_o);
    else n_pass++;
    n_checks++;
    if (best_update_o !== 1'b0) $display("FAIL reset_update got %b required 0", best_update_o);
    else n_pass++;
    check_best("reset");
    result_valid_i = '0;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_single();
    core_bits[2]  = 10'h1A0;
    core_nonce[2] = 256'hABC;
    step(4'b0100, 1'b0);
    n_checks++;
    if (result_count_o !== 32'd1 || best_update_o !== 1'b0)
      $display("FAIL single_stage1 got count=%0d upd=%b required 1,0", result_count_o, best_update_o);
    else n_pass++;
    step('0, 1'b0);
    n_checks++;
    if (best_update_o !== 1'b1 || best_bits_off_o !== 10'h1A0 || best_nonce_o !== 256'hABC ||
        best_core_o !== 2'd2)
      $display("FAIL single_best got upd=%b bits=%h core=%0d required 1,1a0,2",
               best_update_o, best_bits_off_o, best_core_o);
    else n_pass++;
    step('0, 1'b0);
    n_checks++;
    if (best_update_o !== 1'b0) $display("FAIL single_pulse_len got %b required 0", best_update_o);
    else n_pass++;
    check_best("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < NC; k++) begin
      core_bits[k]  = 10'h200 - 10'(k * 16);
      core_nonce[k] = 256'(k + 100);
    end
    for (int c = 0; c < 8; c++) step(4'hF, 1'b0);
    n_checks++;
    if (result_count_o !== 32'd8) $display("FAIL rr_count got %0d required 8", result_count_o);
    else n_pass++;
    drain();
    // Idle cycles must not move the pointer: next grant on all-valid is core 0.
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    drain();
    check_best("rr");
  endtask

  task automatic test_tie();
    step('0, 1'b1);
    core_bits[1] = 10'h050; core_nonce[1] = 256'h111;
    core_bits[3] = 10'h050; core_nonce[3] = 256'h333;
    step(4'b0010, 1'b0);
    step(4'b1000, 1'b0);
    drain();
    n_checks++;
    if (best_core_o !== 2'd1) $display("FAIL tie_core got %0d required 1", best_core_o);
    else n_pass++;
    check_best("tie");
  endtask

  task automatic test_reset_best_drop();
    step('0, 1'b1);
    core_bits[0] = 10'h030; core_nonce[0] = 256'h30;
    step(4'b0001, 1'b0);
    drain();
    check_best("rb_setup");
    core_bits[0] = 10'h010; core_nonce[0] = 256'h10;
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    drain();
    n_checks++;
    if (best_bits_off_o !== 10'h3FF || result_count_o !== 32'd0)
      $display("FAIL rb_drop got bits=%h count=%0d required 3ff,0", best_bits_off_o, result_count_o);
    else n_pass++;
    check_best("rb_drop");
  endtask

  task automatic test_all_ones();
    core_bits[0] = 10'h3FF; core_nonce[0] = 256'hF0F;
    step(4'b0001, 1'b0);
    drain();
    n_checks++;
    if (result_count_o !== 32'd1 || best_bits_off_o !== 10'h3FF)
      $display("FAIL all_ones got count=%0d bits=%h required 1,3ff", result_count_o, best_bits_off_o);
    else n_pass++;
    check_best("all_ones");
  endtask

  task automatic test_reset_mid();
    core_bits[2] = 10'h001; core_nonce[2] = 256'h2;
    step(4'b0100, 1'b0);
    do_reset();
    drain();
    check_best("reset_mid");
  endtask

  task automatic test_back_to_back();
    step('0, 1'b1);
    pend = '0;
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < NC; k++) begin
        if (!pend[k] && $urandom_range(0, 3) != 0) begin
          pend[k]       = 1'b1;
          core_bits[k]  = 10'($urandom_range(0, 1023));
          core_nonce[k] = {8{$urandom()}};
        end
      end
      step(pend, 1'b0);
    end
    drain();
    check_best("b2b");
  endtask

`ifdef BEST_THRESHOLD_HIT_EN
  task automatic test_threshold();
    step('0, 1'b1);
    core_bits[0] = 10'h080; core_nonce[0] = 256'h80;
    step(4'b0001, 1'b0);
    drain();
    n_checks++;
    if (hit_o !== 1'b0) $display("FAIL hit_first got %b required 0", hit_o);
    else n_pass++;
    core_bits[1] = 10'h03F; core_nonce[1] = 256'h3F;
    step(4'b0010, 1'b0);
    drain();
    n_checks++;
    if (hit_o !== 1'b1) $display("FAIL hit_second got %b required 1", hit_o);
    else n_pass++;
    step('0, 1'b1);
    n_checks++;
    if (hit_o !== 1'b0) $display("FAIL hit_clear got %b required 0", hit_o);
    else n_pass++;
    check_best("hit");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tie();
    test_reset_best_drop();
    test_all_ones();
    test_reset_mid();
    test_back_to_back();
`ifdef BEST_THRESHOLD_HIT_EN
    test_threshold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
